// File: rtl/vga_frame_engine_if.sv
// Signal bundle between vga_frame_engine and its ppu/statemachine/DAC neighbours.
// master = the frame engine, slave = everything that feeds it or consumes its outputs.
interface vga_frame_engine_if #(
    parameter int COLOR_W     = 10,
    parameter int NUM_SPRITES = 2,
    parameter int ATTR_W      = 32
);
    logic [NUM_SPRITES*ATTR_W-1:0] attr_in;
    logic                          attr_valid;
    logic [COLOR_W-1:0]            red_in;
    logic [COLOR_W-1:0]            green_in;
    logic [COLOR_W-1:0]            blue_in;
    logic [11:0]                   hcount;
    logic [11:0]                   vcount;
    logic                          active;
    logic                          frame_start;
    logic                          hsync;
    logic                          vsync;
    logic                          blank_n;
    logic [COLOR_W-1:0]            red;
    logic [COLOR_W-1:0]            green;
    logic [COLOR_W-1:0]            blue;
    logic [NUM_SPRITES*ATTR_W-1:0] attr_out;
    logic                          attr_commit;
    logic [15:0]                   frame_count;

    modport master (
        input  attr_in, attr_valid, red_in, green_in, blue_in,
        output hcount, vcount, active, frame_start, hsync, vsync, blank_n,
        output red, green, blue, attr_out, attr_commit, frame_count
    );

    modport slave (
        output attr_in, attr_valid, red_in, green_in, blue_in,
        input  hcount, vcount, active, frame_start, hsync, vsync, blank_n,
        input  red, green, blue, attr_out, attr_commit, frame_count
    );
endinterface

// File: rtl/vga_frame_engine.sv
// Parametrised VGA timing, pipeline-aligned sync/blank/colour and vblank-committed sprite attributes.
// Optional feature: define FRAME_COUNTER_EN to enable frame_count (otherwise tied to 0).
module vga_frame_engine #(
    parameter int H_ACTIVE    = 1280,
    parameter int H_FP        = 48,
    parameter int H_SYNC      = 112,
    parameter int H_BP        = 248,
    parameter int V_ACTIVE    = 1024,
    parameter int V_FP        = 1,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 38,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int COLOR_W     = 10,
    parameter int PIPE_DELAY  = 2,
    parameter int NUM_SPRITES = 2,
    parameter int ATTR_W      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    vga_frame_engine_if.master   bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int AW      = NUM_SPRITES * ATTR_W;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0]        hcount;
    logic [11:0]        vcount;
    logic               active;
    logic               frame_start;
    logic               vblank_entry;
    logic               hs_cond;
    logic               vs_cond;
    logic [2:0]         raw;
    logic [2:0]         dout;
    logic               gate;
    logic [COLOR_W-1:0] red_q;
    logic [COLOR_W-1:0] green_q;
    logic [COLOR_W-1:0] blue_q;
    logic [AW-1:0]      shadow;
    logic [AW-1:0]      attr_q;
    logic               pending;
    logic               commit_q;
    logic [15:0]        frame_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 12'd1;
        end else begin
            hcount <= hcount + 12'd1;
        end
    end

    assign active       = (hcount < H_ACT) && (vcount < V_ACT);
    assign frame_start  = (hcount == '0) && (vcount == '0);
    assign vblank_entry = (hcount == '0) && (vcount == V_ACT);
    assign hs_cond      = (hcount >= HS_START) && (hcount < HS_END);
    assign vs_cond      = (vcount >= VS_START) && (vcount < VS_END);

    // Stages carry "condition true" bits {hs, vs, blank_n}; polarity is applied at the output,
    // so the all-zero reset value means inactive sync and blanked video.
    // taps[2:0] is the undelayed stage, taps[3k+2:3k] is delay stage k.
    assign raw = {hs_cond, vs_cond, active};

    logic [3*PIPE_DELAY-1:0] dly;
    logic [3*PIPE_DELAY+2:0] taps;
    assign taps = {dly, raw};

    always_ff @(posedge clock) begin
        if (reset) dly <= '0;
        else       dly <= taps[3*PIPE_DELAY-1:0];
    end

    assign dout = taps[3*PIPE_DELAY +: 3];
    assign gate = taps[3*(PIPE_DELAY-1)];

    always_ff @(posedge clock) begin
        if (reset) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            red_q   <= gate ? bus.red_in   : '0;
            green_q <= gate ? bus.green_in : '0;
            blue_q  <= gate ? bus.blue_in  : '0;
        end
    end

    // A write coinciding with vblank entry bypasses the shadow straight to attr_out.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow   <= '0;
            attr_q   <= '0;
            pending  <= 1'b0;
            commit_q <= 1'b0;
        end else if (bus.attr_valid && vblank_entry) begin
            shadow   <= bus.attr_in;
            attr_q   <= bus.attr_in;
            pending  <= 1'b0;
            commit_q <= 1'b1;
        end else if (vblank_entry && pending) begin
            attr_q   <= shadow;
            pending  <= 1'b0;
            commit_q <= 1'b1;
        end else begin
            if (bus.attr_valid) begin
                shadow  <= bus.attr_in;
                pending <= 1'b1;
            end
            commit_q <= 1'b0;
        end
    end

`ifdef FRAME_COUNTER_EN
    // Counts on the wrap into (0,0), so the first pulse after reset is never counted.
    always_ff @(posedge clock) begin
        if (reset)                                   frame_q <= '0;
        else if (hcount == H_LAST && vcount == V_LAST) frame_q <= frame_q + 16'd1;
    end
`else
    assign frame_q = '0;
`endif

    assign bus.hcount      = hcount;
    assign bus.vcount      = vcount;
    assign bus.active      = active;
    assign bus.frame_start = frame_start;
    assign bus.hsync       = dout[2] ? HS_POL : ~HS_POL;
    assign bus.vsync       = dout[1] ? VS_POL : ~VS_POL;
    assign bus.blank_n     = dout[0];
    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.attr_out    = attr_q;
    assign bus.attr_commit = commit_q;
    assign bus.frame_count = frame_q;
endmodule

// File: doc/vga_frame_engine.md
# vga_frame_engine

Parametrised successor to the console's fixed 1280x1024 video path. It generates pixel/line counters and VGA sync and blank signals for any timing mode. It delays sync and blank to match a configurable pixel-pipeline latency in the ppu, and blanks colour outside the active area. It also double-buffers sprite attributes from the statemachine, committing them only at vblank entry so the ppu never sees a mid-frame update.

## Interface
Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 112, horizontal sync width
- H_BP, 248, horizontal back porch
- V_ACTIVE, 1024, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width
- V_BP, 38, vertical back porch
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level
- COLOR_W, 10, bits per colour channel
- PIPE_DELAY, 2, ppu latency in clocks from counters to colour; legal range ≥1
- NUM_SPRITES, 2, sprite attribute slots
- ATTR_W, 32, bits per sprite attribute

Ports:
- clock  in  1  pixel clock (108 MHz in the default mode)
- reset  in  1  synchronous, active-high
- attr_in  in  NUM_SPRITES*ATTR_W  new sprite attributes from the statemachine
- attr_valid  in  1  one-cycle write strobe for attr_in
- red_in, green_in, blue_in  in  COLOR_W each  ppu colour
- hcount, vcount  out  12 each  counter position (undelayed), for the ppu
- active  out  1  hcount<H_ACTIVE && vcount<V_ACTIVE (undelayed)
- frame_start  out  1  pulse when hcount=0 && vcount=0
- hsync, vsync, blank_n  out  1 each  delayed VGA controls
- red, green, blue  out  COLOR_W each  blanked colour, aligned with hsync/vsync
- attr_out  out  NUM_SPRITES*ATTR_W  committed attributes
- attr_commit  out  1  pulse in the cycle attr_out updates
- frame_count  out  16  frames since reset

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = the vertical sum.
- hcount increments every clock. At H_TOTAL-1 it wraps to 0 and vcount increments. vcount wraps to 0 after V_TOTAL-1.
- The raw hsync condition is H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC. The raw vsync condition uses the same form on vcount. Output level is the *_POL value while the condition is true, else its inverse.
- Raw blank_n equals active.
- The delay line is a shift register PIPE_DELAY deep carrying hsync, vsync and blank_n.
- Colour stage: red/green/blue register {colour}_in when delayed-stage PIPE_DELAY-1 blank_n is 1, else 0.
- Attribute shadow:
  - attr_valid loads attr_in into the shadow register and sets pending.
  - A later write before commit overwrites the shadow (last write wins).
- Commit event is hcount==0 && vcount==V_ACTIVE (vblank entry):
  - If pending is set, attr_out ← shadow, attr_commit=1 for one cycle, pending cleared.
  - If pending is clear, nothing changes and attr_commit stays 0.
- Simultaneous attr_valid and commit event: attr_in is written directly to attr_out and to the shadow, attr_commit=1, pending stays 0.
- frame_count increments (mod 2^16) at each frame_start after reset.

## Timing
- Reset values:
  - hcount=0, vcount=0.
  - All delay stages inactive: sync at !POL, blank_n=0.
  - red, green, blue = 0.
  - attr_out=0, pending=0, attr_commit=0, frame_count=0.
- Reset asserted mid-frame: all of the above in the next cycle. The in-flight delay line is discarded and the shadow is lost.
- First cycle after reset deasserts: hcount=0, vcount=0, active=1, frame_start=1. frame_count does not count this pulse.
- Outputs hsync, vsync, blank_n, red, green and blue for counter value (h,v) at cycle t appear at cycle t+PIPE_DELAY.
- Colour inputs for (h,v) must be valid at t+PIPE_DELAY-1.
- attr_out changes in the cycle after the commit event is registered. attr_commit is high in that same cycle.

## Configuration
- FRAME_COUNTER_EN defined: frame_count behaves as in Operation.
- FRAME_COUNTER_EN undefined: the counter logic is removed, and frame_count is tied to 0 and never changes.

## Test plan
All scenarios use a small mode: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), PIPE_DELAY=2, HS_POL=VS_POL=0.
- Reset: hold reset 3 cycles mid-line -> hcount=vcount=0, hsync=vsync=1, blank_n=0, colours 0, attr_out=0. In the first cycle after release, frame_start=1.
- Line timing: free-run 2 frames -> hsync=0 on output cycles 12..14 of each 16-cycle line. blank_n=1 on cycles 2..9 for lines 0..3 only. vsync=0 for lines 5..6 (offset 2 clocks). frame_start every 128 cycles.
- Blanking: red_in=10'h3FF held constant -> red=3FF for exactly 8 cycles per active line, 0 elsewhere, and 0 for all of lines 4..7.
- Commit: attr_valid with 0xA5 at (h=3,v=1) -> attr_out stays 0 until the cycle after (0,4). It then reads 0xA5, with attr_commit high for one cycle and no further pulse in the next frame.
- Collisions: writes 0x11 then 0x22 before vblank -> 0x22 is committed. A write of 0x33 exactly at (0,4) -> 0x33 is committed in the same event and pending stays 0.
- With FRAME_COUNTER_EN, preload via 65536 frames (or force) -> frame_count wraps 0xFFFF→0x0000. Without FRAME_COUNTER_EN, frame_count stays 0 throughout.
